// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-SRAM accesses with sub-word stores and WB forwarding,
// holds one instruction in the MEM slot, and aligns/extends returned load data.
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                es_valid,
  output logic                ms_allowin,
  input  logic                es_mem_en,
  input  logic                es_mem_we,
  input  logic [1:0]          es_mem_size,
  input  logic                es_mem_sext,
  input  logic [ADDR_W-1:0]   es_addr,
  input  logic [DATA_W-1:0]   es_result,
  input  logic [REG_AW-1:0]   es_rt_num,
  input  logic [DATA_W-1:0]   es_rt_data,
  input  logic [REG_AW-1:0]   es_dest,
  input  logic                fwd_wb_wen,
  input  logic [REG_AW-1:0]   fwd_wb_dest,
  input  logic [DATA_W-1:0]   fwd_wb_wdata,
  output logic                data_sram_en,
  output logic [DATA_W/8-1:0] data_sram_wen,
  output logic [ADDR_W-1:0]   data_sram_addr,
  output logic [DATA_W-1:0]   data_sram_wdata,
  input  logic [DATA_W-1:0]   data_sram_rdata,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [REG_AW-1:0]   ms_dest,
  output logic                ms_wen,
  output logic [DATA_W-1:0]   ms_wdata,
  output logic                ms_addr_err
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);

  logic                r_valid;
  logic [REG_AW-1:0]   r_dest;
  logic [DATA_W-1:0]   r_result;
  logic                r_mem_en;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_sext;
  logic [OFFW-1:0]     r_off;
  logic                r_err;
  logic                r_held;
  logic [DATA_W-1:0]   r_hold_data;

  logic                w_accept;
  logic                w_mis;
  logic                w_is_load;
  logic [OFFW-1:0]     w_off;
  logic [DATA_W-1:0]   w_src;
  logic [DATA_W-1:0]   w_store_data;
  logic [NB-1:0]       w_mask;
  logic [DATA_W-1:0]   w_rsrc;
  logic [DATA_W-1:0]   w_shift;
  logic [DATA_W-1:0]   w_load;

  assign ms_allowin = !r_valid || ws_allowin;
  assign w_accept   = es_valid && ms_allowin;
  assign w_off      = es_addr[OFFW-1:0];

  // A dword access on a 32-bit datapath has no legal alignment.
  always_comb begin
    w_mis = 1'b0;
    case (es_mem_size)
      2'd1:    w_mis = es_addr[0];
      2'd2:    w_mis = |es_addr[1:0];
      2'd3:    w_mis = (DATA_W == 32) ? 1'b1 : |es_addr[2:0];
      default: w_mis = 1'b0;
    endcase
  end

  assign w_src = (fwd_wb_wen && (fwd_wb_dest != '0) && (fwd_wb_dest == es_rt_num))
               ? fwd_wb_wdata : es_rt_data;

  always_comb begin
    w_store_data = w_src;
    case (es_mem_size)
      2'd0:    w_store_data = {NB{w_src[7:0]}};
      2'd1:    w_store_data = {(NB/2){w_src[15:0]}};
      2'd2:    w_store_data = {(NB/4){w_src[31:0]}};
      default: w_store_data = w_src;
    endcase
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (1 << es_mem_size)) w_mask[i] = 1'b1;
    end
  end

  assign data_sram_en    = w_accept && es_mem_en && !w_mis;
  assign data_sram_wen   = (data_sram_en && es_mem_we) ? (w_mask << w_off) : '0;
  assign data_sram_addr  = data_sram_en ? {es_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}} : '0;
  assign data_sram_wdata = (data_sram_en && es_mem_we) ? w_store_data : '0;

  assign w_is_load = r_mem_en && !r_we;

  // rdata is only valid in the first MEM cycle, so a stalled load snapshots it once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid     <= 1'b0;
      r_dest      <= '0;
      r_result    <= '0;
      r_mem_en    <= 1'b0;
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_sext      <= 1'b0;
      r_off       <= '0;
      r_err       <= 1'b0;
      r_held      <= 1'b0;
      r_hold_data <= '0;
    end else begin
      if (w_accept) begin
        r_valid  <= 1'b1;
        r_dest   <= es_dest;
        r_result <= es_result;
        r_mem_en <= es_mem_en;
        r_we     <= es_mem_we;
        r_size   <= es_mem_size;
        r_sext   <= es_mem_sext;
        r_off    <= w_off;
        r_err    <= es_mem_en && w_mis;
        r_held   <= 1'b0;
      end else if (ws_allowin) begin
        r_valid <= 1'b0;
        r_held  <= 1'b0;
      end else if (r_valid && w_is_load && !r_held) begin
        r_hold_data <= data_sram_rdata;
        r_held      <= 1'b1;
      end
    end
  end

  assign w_rsrc  = r_held ? r_hold_data : data_sram_rdata;
  assign w_shift = w_rsrc >> {r_off, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (r_size)
      2'd0: w_load = r_sext ? DATA_W'($signed(w_shift[7:0]))  : DATA_W'(w_shift[7:0]);
      2'd1: w_load = r_sext ? DATA_W'($signed(w_shift[15:0])) : DATA_W'(w_shift[15:0]);
      2'd2: w_load = r_sext ? DATA_W'($signed(w_shift[31:0])) : DATA_W'(w_shift[31:0]);
      default: w_load = w_shift;
    endcase
  end

  assign ms_to_ws_valid = r_valid;
  assign ms_dest        = r_dest;
  assign ms_wdata       = w_is_load ? w_load : r_result;
  assign ms_wen         = r_valid && (r_dest != '0) && !r_we && !r_err;
  assign ms_addr_err    = r_valid && r_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a 32-bit instance checked every cycle against a byte-level
// memory model, plus a 64-bit instance exercised with directed dword/stall/reset vectors.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        es_valid = 1'b0, es_mem_en = 1'b0, es_mem_we = 1'b0, es_mem_sext = 1'b0;
  logic [1:0]  es_mem_size = 2'd0;
  logic [31:0] es_addr = '0, es_result = '0, es_rt_data = '0, fwd_wb_wdata = '0;
  logic [4:0]  es_rt_num = '0, es_dest = '0, fwd_wb_dest = '0;
  logic        fwd_wb_wen = 1'b0, ws_allowin = 1'b1;
  logic        ms_allowin, data_sram_en, ms_to_ws_valid, ms_wen, ms_addr_err;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, ms_wdata;
  logic [31:0] data_sram_rdata = '0;
  logic [4:0]  ms_dest;

  logic        d_resetn = 1'b0;
  logic        d_es_valid = 1'b0, d_es_mem_en = 1'b0, d_es_mem_we = 1'b0, d_es_mem_sext = 1'b0;
  logic [1:0]  d_es_mem_size = 2'd0;
  logic [31:0] d_es_addr = '0;
  logic [63:0] d_es_result = '0, d_es_rt_data = '0, d_fwd_wdata = '0;
  logic [4:0]  d_es_rt_num = '0, d_es_dest = '0, d_fwd_dest = '0;
  logic        d_fwd_wen = 1'b0, d_ws_allowin = 1'b1;
  logic        d_ms_allowin, d_sram_en, d_ms_to_ws_valid, d_ms_wen, d_ms_addr_err;
  logic [7:0]  d_sram_wen;
  logic [31:0] d_sram_addr;
  logic [63:0] d_sram_wdata, d_ms_wdata;
  logic [63:0] d_sram_rdata = '0;
  logic [4:0]  d_ms_dest;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) u32 (
    .clk(clk), .resetn(resetn), .es_valid(es_valid), .ms_allowin(ms_allowin),
    .es_mem_en(es_mem_en), .es_mem_we(es_mem_we), .es_mem_size(es_mem_size),
    .es_mem_sext(es_mem_sext), .es_addr(es_addr), .es_result(es_result),
    .es_rt_num(es_rt_num), .es_rt_data(es_rt_data), .es_dest(es_dest),
    .fwd_wb_wen(fwd_wb_wen), .fwd_wb_dest(fwd_wb_dest), .fwd_wb_wdata(fwd_wb_wdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_dest(ms_dest), .ms_wen(ms_wen),
    .ms_wdata(ms_wdata), .ms_addr_err(ms_addr_err)
  );

  mem_access_stage #(.DATA_W(64), .ADDR_W(32), .REG_AW(5)) u64 (
    .clk(clk), .resetn(d_resetn), .es_valid(d_es_valid), .ms_allowin(d_ms_allowin),
    .es_mem_en(d_es_mem_en), .es_mem_we(d_es_mem_we), .es_mem_size(d_es_mem_size),
    .es_mem_sext(d_es_mem_sext), .es_addr(d_es_addr), .es_result(d_es_result),
    .es_rt_num(d_es_rt_num), .es_rt_data(d_es_rt_data), .es_dest(d_es_dest),
    .fwd_wb_wen(d_fwd_wen), .fwd_wb_dest(d_fwd_dest), .fwd_wb_wdata(d_fwd_wdata),
    .data_sram_en(d_sram_en), .data_sram_wen(d_sram_wen),
    .data_sram_addr(d_sram_addr), .data_sram_wdata(d_sram_wdata),
    .data_sram_rdata(d_sram_rdata), .ws_allowin(d_ws_allowin),
    .ms_to_ws_valid(d_ms_to_ws_valid), .ms_dest(d_ms_dest), .ms_wen(d_ms_wen),
    .ms_wdata(d_ms_wdata), .ms_addr_err(d_ms_addr_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte memory index: keeps the test-plan address regions (0x1xxx, 0x2xxx, 0x3xxx) apart.
  function automatic int memIdx(input logic [31:0] a);
    return int'({a[13:12], a[5:0]});
  endfunction

  function automatic logic [7:0] initByte(input int i);
    case (i)
      8'h80:   return 8'h34;
      8'h81:   return 8'h12;
      8'h82:   return 8'h01;
      8'h83:   return 8'h80;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  logic [7:0] sMem [0:255];
  logic [7:0] mMem [0:255];

  // SRAM emulation for the 32-bit DUT: read data is meaningful only the cycle after an access.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) sMem[i] <= initByte(i);
      data_sram_rdata <= '0;
    end else if (data_sram_en) begin
      for (int i = 0; i < 4; i++)
        if (data_sram_wen[i]) sMem[memIdx(data_sram_addr + 32'(i))] <= data_sram_wdata[8*i +: 8];
      data_sram_rdata <= {sMem[memIdx(data_sram_addr + 32'd3)], sMem[memIdx(data_sram_addr + 32'd2)],
                          sMem[memIdx(data_sram_addr + 32'd1)], sMem[memIdx(data_sram_addr)]};
    end else begin
      data_sram_rdata <= $urandom;
    end
  end

  always @(posedge clk) begin
    d_sram_rdata <= d_sram_en ? 64'h8877_6655_4433_2211 : {$urandom, $urandom};
  end

  function automatic logic expMis(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'b00;
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] storeSrc();
    return (fwd_wb_wen && fwd_wb_dest != 0 && fwd_wb_dest == es_rt_num) ? fwd_wb_wdata : es_rt_data;
  endfunction

  function automatic logic [31:0] loadVal(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int b = 0; b < n; b++) v[8*b +: 8] = mMem[memIdx(a + 32'(b))];
    if (sx && v[8*n-1]) for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
    return v[31:0];
  endfunction

  logic        mValid = 1'b0, mWen = 1'b0, mErr = 1'b0;
  logic [4:0]  mDest = '0;
  logic [31:0] mWdata = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mValid <= 1'b0; mWen <= 1'b0; mErr <= 1'b0; mDest <= '0; mWdata <= '0;
      for (int i = 0; i < 256; i++) mMem[i] <= initByte(i);
    end else if (es_valid && (!mValid || ws_allowin)) begin
      mValid <= 1'b1;
      mDest  <= es_dest;
      mErr   <= es_mem_en && expMis(es_mem_size, es_addr);
      mWen   <= (es_dest != 0) && !es_mem_we && !(es_mem_en && expMis(es_mem_size, es_addr));
      mWdata <= (es_mem_en && !es_mem_we) ? loadVal(es_addr, es_mem_size, es_mem_sext) : es_result;
      if (es_mem_en && es_mem_we && !expMis(es_mem_size, es_addr))
        for (int b = 0; b < (1 << es_mem_size); b++)
          mMem[memIdx(es_addr + 32'(b))] <= storeSrc() >> (8 * b);
    end else if (ws_allowin) begin
      mValid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic expEn;
    int n, off;
    logic [3:0]  expWen;
    logic [31:0] expWd, src;
    expEn  = es_valid && (!mValid || ws_allowin) && es_mem_en && !expMis(es_mem_size, es_addr);
    n      = 1 << es_mem_size;
    off    = int'(es_addr[1:0]);
    src    = storeSrc();
    expWen = '0;
    expWd  = '0;
    for (int i = 0; i < 4; i++) begin
      expWen[i] = expEn && es_mem_we && (i >= off) && (i < off + n);
      if (n <= 4) expWd[8*i +: 8] = src[8*(i % n) +: 8];
    end
    checkOutput("m_allowin", 64'(ms_allowin), 64'(!mValid || ws_allowin));
    checkOutput("m_valid", 64'(ms_to_ws_valid), 64'(mValid));
    checkOutput("m_wen", 64'(ms_wen), 64'(mValid && mWen));
    checkOutput("m_addr_err", 64'(ms_addr_err), 64'(mValid && mErr));
    if (mValid) checkOutput("m_dest", 64'(ms_dest), 64'(mDest));
    if (mValid && !mErr) checkOutput("m_wdata", 64'(ms_wdata), 64'(mWdata));
    checkOutput("m_sram_en", 64'(data_sram_en), 64'(expEn));
    checkOutput("m_sram_wen", 64'(data_sram_wen), 64'(expWen));
    if (expEn) checkOutput("m_sram_addr", 64'(data_sram_addr), 64'({es_addr[31:2], 2'b00}));
    if (expEn && es_mem_we) checkOutput("m_sram_wdata", 64'(data_sram_wdata), 64'(expWd));
    if (!es_valid) checkOutput("m_sram_idle", {data_sram_addr, data_sram_wdata}, 64'd0);
  end

  task automatic applyStimulus(input logic v, me, we, input logic [1:0] sz, input logic sx,
                               input logic [31:0] ad, res, input logic [4:0] rt,
                               input logic [31:0] rtd, input logic [4:0] dst);
    @(posedge clk); #1;
    es_valid = v; es_mem_en = me; es_mem_we = we; es_mem_size = sz; es_mem_sext = sx;
    es_addr = ad; es_result = res; es_rt_num = rt; es_rt_data = rtd; es_dest = dst;
  endtask

  task automatic applyStim64(input logic v, me, we, input logic [1:0] sz, input logic sx,
                             input logic [31:0] ad, input logic [63:0] rtd, input logic [4:0] dst);
    @(posedge clk); #1;
    d_es_valid = v; d_es_mem_en = me; d_es_mem_we = we; d_es_mem_size = sz;
    d_es_mem_sext = sx; d_es_addr = ad; d_es_rt_data = rtd; d_es_dest = dst;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_allowin", 64'(ms_allowin), 64'd1);
    checkOutput("rst_valid", 64'(ms_to_ws_valid), 64'd0);
    checkOutput("rst_wen", 64'(ms_wen), 64'd0);
    checkOutput("rst_addr_err", 64'(ms_addr_err), 64'd0);
    checkOutput("rst_dest", 64'(ms_dest), 64'd0);
    checkOutput("rst_wdata", 64'(ms_wdata), 64'd0);
    checkOutput("rst_sram_en", 64'(data_sram_en), 64'd0);
    checkOutput("rst_sram_wen", 64'(data_sram_wen), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    d_resetn = 1'b1;

    applyStimulus(1, 1, 1, 2'd0, 0, 32'h1003, 32'h0, 5'd3, 32'h1234_56A5, 5'd0);
    @(negedge clk);
    checkOutput("sb_en", 64'(data_sram_en), 64'd1);
    checkOutput("sb_wen", 64'(data_sram_wen), 64'b1000);
    checkOutput("sb_wdata", 64'(data_sram_wdata), 64'hA5A5_A5A5);
    checkOutput("sb_addr", 64'(data_sram_addr), 64'h1000);

    applyStimulus(1, 1, 0, 2'd1, 1, 32'h2002, 32'h0, 5'd0, 32'h0, 5'd7);
    @(negedge clk);
    checkOutput("lh_addr", 64'(data_sram_addr), 64'h2000);
    checkOutput("lh_wen0", 64'(data_sram_wen), 64'd0);
    applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0);
    @(negedge clk);
    checkOutput("lh_wdata", 64'(ms_wdata), 64'hFFFF_8001);
    checkOutput("lh_wen", 64'(ms_wen), 64'd1);

    applyStimulus(1, 1, 1, 2'd2, 0, 32'h1004, 32'h0, 5'd5, 32'h1111_1111, 5'd0);
    fwd_wb_wen = 1'b1; fwd_wb_dest = 5'd5; fwd_wb_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("fwd_wdata", 64'(data_sram_wdata), 64'hDEAD_BEEF);
    checkOutput("fwd_wen", 64'(data_sram_wen), 64'hF);
    applyStimulus(1, 1, 1, 2'd2, 0, 32'h1008, 32'h0, 5'd0, 32'h1111_1111, 5'd0);
    fwd_wb_dest = 5'd0;
    @(negedge clk);
    checkOutput("nofwd_wdata", 64'(data_sram_wdata), 64'h1111_1111);

    applyStimulus(1, 1, 0, 2'd2, 0, 32'h3001, 32'h0, 5'd0, 32'h0, 5'd9);
    fwd_wb_wen = 1'b0;
    @(negedge clk);
    checkOutput("mis_en", 64'(data_sram_en), 64'd0);
    applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0);
    @(negedge clk);
    checkOutput("mis_err", 64'(ms_addr_err), 64'd1);
    checkOutput("mis_wen", 64'(ms_wen), 64'd0);

    // Load word, then stall three cycles with a second load waiting behind it.
    applyStimulus(1, 1, 0, 2'd2, 0, 32'h1004, 32'h0, 5'd0, 32'h0, 5'd10);
    applyStimulus(1, 1, 0, 2'd0, 1, 32'h1003, 32'h0, 5'd0, 32'h0, 5'd11);
    ws_allowin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_wdata", 64'(ms_wdata), 64'hDEAD_BEEF);
      checkOutput("stall_allowin", 64'(ms_allowin), 64'd0);
      checkOutput("stall_no_issue", 64'(data_sram_en), 64'd0);
    end
    @(posedge clk); #1;
    ws_allowin = 1'b1;
    @(negedge clk);
    checkOutput("resume_en", 64'(data_sram_en), 64'd1);
    applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0);
    @(negedge clk);
    checkOutput("lb_sext", 64'(ms_wdata), 64'hFFFF_FFA5);

    applyStimulus(1, 0, 0, 2'd0, 0, 32'h0, 32'h55AA, 5'd0, 32'h0, 5'd3);
    applyStimulus(1, 1, 0, 2'd1, 0, 32'h2000, 32'h0, 5'd0, 32'h0, 5'd4);
    applyStimulus(1, 1, 1, 2'd1, 0, 32'h1006, 32'h0, 5'd0, 32'h0000_CAFE, 5'd0);
    applyStimulus(1, 1, 0, 2'd2, 0, 32'h1004, 32'h0, 5'd0, 32'h0, 5'd6);
    applyStimulus(1, 1, 0, 2'd3, 0, 32'h1000, 32'h0, 5'd0, 32'h0, 5'd8);
    @(negedge clk);
    checkOutput("b2b_lw", 64'(ms_wdata), 64'hCAFE_BEEF);
    applyStimulus(1, 1, 0, 2'd0, 0, 32'h2003, 32'h0, 5'd0, 32'h0, 5'd2);
    @(negedge clk);
    checkOutput("dw32_err", 64'(ms_addr_err), 64'd1);
    applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0);
    @(negedge clk);
    checkOutput("lbu", 64'(ms_wdata), 64'h80);

    // 64-bit datapath
    applyStim64(1, 1, 1, 2'd1, 0, 32'h16, 64'hBEEF, 5'd0);
    @(negedge clk);
    checkOutput("d_sh_wen", 64'(d_sram_wen), 64'hC0);
    checkOutput("d_sh_wdata", d_sram_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    checkOutput("d_sh_addr", 64'(d_sram_addr), 64'h10);
    applyStim64(1, 1, 0, 2'd2, 1, 32'hC, 64'h0, 5'd3);
    @(negedge clk);
    checkOutput("d_lw_addr", 64'(d_sram_addr), 64'h8);
    applyStim64(1, 1, 0, 2'd0, 0, 32'h9, 64'h0, 5'd4);
    @(negedge clk);
    checkOutput("d_lw_wdata", d_ms_wdata, 64'hFFFF_FFFF_8877_6655);
    checkOutput("d_lw_wen", 64'(d_ms_wen), 64'd1);
    applyStim64(1, 1, 0, 2'd3, 0, 32'h8, 64'h0, 5'd5);
    @(negedge clk);
    checkOutput("d_lbu", d_ms_wdata, 64'h22);
    checkOutput("d_ld_en", 64'(d_sram_en), 64'd1);
    checkOutput("d_ld_wen", 64'(d_sram_wen), 64'd0);
    applyStim64(0, 0, 0, 2'd0, 0, 32'h0, 64'h0, 5'd0);
    d_ws_allowin = 1'b0;
    @(negedge clk);
    checkOutput("d_ld_wdata", d_ms_wdata, 64'h8877_6655_4433_2211);
    checkOutput("d_ld_allowin", 64'(d_ms_allowin), 64'd0);
    @(negedge clk);
    checkOutput("d_ld_hold", d_ms_wdata, 64'h8877_6655_4433_2211);
    @(posedge clk); #2;
    d_resetn = 1'b0;
    #1;
    checkOutput("d_rst_valid", 64'(d_ms_to_ws_valid), 64'd0);
    checkOutput("d_rst_allowin", 64'(d_ms_allowin), 64'd1);
    checkOutput("d_rst_wen", 64'(d_ms_wen), 64'd0);
    @(negedge clk);
    checkOutput("d_rst_stays", 64'(d_ms_to_ws_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage that sits between the execute and write-back stages of the 5-stage CPU. It issues data-SRAM accesses with sub-word stores (byte/half/word, plus dword when `DATA_W=64`), forwards write-back results into store data, and checks alignment. It registers the instruction into the MEM slot with a valid/allowin handshake, then aligns and extends returned load data. It holds SRAM read data across write-back stalls.

## Interface
- `DATA_W`, default 32: datapath width; 32 or 64 only.
- `ADDR_W`, default 32: data-SRAM byte-address width.
- `REG_AW`, default 5: register-number width.

- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `es_valid` in 1: execute stage presents an instruction.
- `ms_allowin` out 1: MEM slot can accept; `!ms_valid || ws_allowin`.
- `es_mem_en` in 1: instruction is a load or store.
- `es_mem_we` in 1: 1 = store, 0 = load.
- `es_mem_size` in 2: 0 byte, 1 half, 2 word, 3 dword (dword legal only when `DATA_W=64`).
- `es_mem_sext` in 1: sign-extend load result.
- `es_addr` in `ADDR_W`: byte address (ALU result).
- `es_result` in `DATA_W`: non-memory result, passed through.
- `es_rt_num` in `REG_AW`: store-data source register number.
- `es_rt_data` in `DATA_W`: store-data register content.
- `es_dest` in `REG_AW`: destination register, 0 = none.
- `fwd_wb_wen` in 1: write-back forwarding write enable.
- `fwd_wb_dest` in `REG_AW`: write-back forwarding destination.
- `fwd_wb_wdata` in `DATA_W`: write-back forwarding data.
- `data_sram_en` out 1: SRAM access enable.
- `data_sram_wen` out `DATA_W/8`: SRAM byte write enables.
- `data_sram_addr` out `ADDR_W`: SRAM address, lane-aligned (low log2(`DATA_W/8`) bits zeroed).
- `data_sram_wdata` out `DATA_W`: SRAM write data.
- `data_sram_rdata` in `DATA_W`: SRAM read data, valid exactly one cycle after the access.
- `ws_allowin` in 1: write-back stage can accept.
- `ms_to_ws_valid` out 1: equals `ms_valid`.
- `ms_dest` out `REG_AW`: destination register for write-back.
- `ms_wen` out 1: register-file write enable for write-back.
- `ms_wdata` out `DATA_W`: result data for write-back.
- `ms_addr_err` out 1: misaligned-access flag for write-back.

## Operation
- Accept is `es_valid && ms_allowin`. On accept, capture valid, dest, result, mem_en, we, size, sext, byte offset `addr[log2(DATA_W/8)-1:0]`, and misalignment into MEM registers. `ms_valid` clears when `ws_allowin` is high and no new accept occurs.
- Misaligned access: half with `addr[0]`, word with `addr[1:0]!=0`, dword with `addr[2:0]!=0`, or size 3 with `DATA_W=32`. Byte accesses are never misaligned.
- Issue is combinational from es inputs: `data_sram_en = accept && es_mem_en && !misaligned`. `data_sram_wen` is nonzero only when `es_mem_we` is also set.
- Store forwarding: `src = (fwd_wb_wen && fwd_wb_dest!=0 && fwd_wb_dest==es_rt_num) ? fwd_wb_wdata : es_rt_data`.
- Store data is `src` replicated per size: byte ×`DATA_W/8`, half ×`DATA_W/16`, word ×`DATA_W/32`.
- Store write enables: a contiguous mask of 1/2/4/8 ones, shifted left by the byte offset.
- Load data: the `rdata` source is shifted right by 8×offset. Keep the low 8/16/32/64 bits, then sign- or zero-extend to `DATA_W`.
- `ms_wdata` is the extended load data for loads and the registered `es_result` otherwise.
- `ms_wen = ms_valid && dest!=0 && !we && !addr_err`, where `we` and `addr_err` are the registered copies.
- Read hold: if `ms_valid && is_load && !ws_allowin && !held`, register `data_sram_rdata` into `hold_data` and set `held`. While `held` is set, the rdata source is `hold_data`; otherwise it is `data_sram_rdata`. `held` clears whenever the slot advances or empties.

## Timing
- Reset (asynchronous, `resetn=0`): `ms_valid`=0, `held`=0, all MEM registers 0. Outputs: `ms_allowin`=1, `ms_to_ws_valid`=0, `ms_wen`=0, `ms_addr_err`=0, `ms_dest`=0, `ms_wdata`=0. SRAM outputs are 0 while `es_valid`=0.
- Reset asserted mid-access: the slot empties immediately, and any late rdata is ignored.
- Latency: an accept in cycle N yields the result on the ms outputs in cycle N+1, combinational from rdata.
- Back-to-back accesses: a new accept may coincide with the slot advancing. No access is issued while `ms_allowin`=0.
- A stall of any length must return the same load value; rdata is valid only in cycle N+1.

## Test plan
- With `DATA_W=32`, store byte 0xA5 to addr 0x1003 → `wen`=4'b1000, `wdata`=0xA5A5A5A5, `addr`=0x1000.
- Load half with sext from 0x2002 where the word is 0x8001_1234 → `ms_wdata`=0xFFFF8001, `ms_wen`=1 in cycle N+1.
- Store word whose rt matches a WB write (`fwd_wb_dest`=5, data 0xDEADBEEF) → `wdata`=0xDEADBEEF. The same case with `fwd_wb_dest`=0 → `es_rt_data` is used.
- Load word from 0x3001 → `data_sram_en`=0, `ms_addr_err`=1, `ms_wen`=0.
- Load, then hold `ws_allowin`=0 for 3 cycles while `data_sram_rdata` changes → `ms_wdata` stays at the cycle-N+1 value and `ms_allowin`=0 throughout.
- With `DATA_W=64`, load dword from 0x8 → `wen`=0, full 64-bit `ms_wdata`. Also assert `resetn` low mid-stall → `ms_to_ws_valid`=0 immediately.
